// File: rtl/hcp_frame_dispatch_pkg.sv
// Shared definitions for the HCP frame dispatcher: dispatch FSM state encoding, default
// ethertype/length limits and descriptor field offsets.
// Descriptor layout: {ts_rec[18:0] at 34:16, ethertype[15:0] at 15:0}.
package hcp_frame_dispatch_pkg;

    localparam logic [15:0] TSMP_ETYPE_DEF    = 16'hFF01;
    localparam logic [10:0] MAX_FRAME_LEN_DEF = 11'd1535;

    localparam int unsigned DATA_W    = 9;
    localparam int unsigned DESC_W    = 35;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned ETYPE_MSB = 15;
    localparam int unsigned ETYPE_LSB = 0;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StDecap   = 2'd1,
        StEncap   = 2'd2,
        StDiscard = 2'd3
    } dispatch_state_e;

    function automatic logic [15:0] desc_etype(input logic [DESC_W-1:0] desc);
        return desc[ETYPE_MSB:ETYPE_LSB];
    endfunction

endpackage

// File: rtl/hcp_dispatch_cnt.sv
// Statistics counters for the HCP frame dispatcher: three 16-bit wrapping counters, each
// advanced by a one-cycle increment strobe. Only built when HCP_DISPATCH_CNT_EN is defined.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   decap_inc, encap_inc, err_inc    increment strobes
//   decap_cnt, encap_cnt, err_cnt    counter values
`ifdef HCP_DISPATCH_CNT_EN
module hcp_dispatch_cnt
    import hcp_frame_dispatch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             decap_inc,
    input  logic             encap_inc,
    input  logic             err_inc,
    output logic [CNT_W-1:0] decap_cnt,
    output logic [CNT_W-1:0] encap_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decap_cnt <= '0;
            encap_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (decap_inc) decap_cnt <= decap_cnt + 16'd1;
            if (encap_inc) encap_cnt <= encap_cnt + 16'd1;
            if (err_inc)   err_cnt   <= err_cnt + 16'd1;
        end
    end

endmodule
`endif

// File: rtl/hcp_frame_dispatch.sv
// HCP frame dispatcher. Steers each whole frame of the serialised 9-bit stream to the
// decapsulation port (ethertype == TSMP_ETYPE) or to the encapsulation port (everything else),
// repairing framing faults: over-long frames are cut with a forced tail, frames losing i_data_wr
// before their tail get a {1'b1,8'h00} pad, frames not starting with a head are dropped.
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   iv_data, i_data_wr          input stream ([8]=head/tail flag) and byte valid
//   iv_descriptor               {ts_rec, ethertype}, sampled on the head cycle
//   ov_decap_data/o_decap_data_wr          TSMP output stream
//   ov_encap_data/o_encap_data_wr          non-TSMP output stream
//   ov_encap_descriptor                    descriptor of the frame on the encap port
//   ov_dispatch_state                      FSM state (debug)
//   ov_decap/encap_pkt_cnt, ov_dispatch_err_cnt  statistics
// Build option: define HCP_DISPATCH_CNT_EN to implement the statistics counters; otherwise the
// counter ports read 0.
module hcp_frame_dispatch
    import hcp_frame_dispatch_pkg::*;
#(
    parameter logic [15:0] TSMP_ETYPE    = TSMP_ETYPE_DEF,
    parameter logic [10:0] MAX_FRAME_LEN = MAX_FRAME_LEN_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] iv_data,
    input  logic [DESC_W-1:0] iv_descriptor,
    input  logic              i_data_wr,
    output logic [DATA_W-1:0] ov_decap_data,
    output logic              o_decap_data_wr,
    output logic [DATA_W-1:0] ov_encap_data,
    output logic [DESC_W-1:0] ov_encap_descriptor,
    output logic              o_encap_data_wr,
    output logic [1:0]        ov_dispatch_state,
    output logic [CNT_W-1:0]  ov_decap_pkt_cnt,
    output logic [CNT_W-1:0]  ov_encap_pkt_cnt,
    output logic [CNT_W-1:0]  ov_dispatch_err_cnt
);

    dispatch_state_e    state;
    logic [10:0]        byte_cnt;
    logic [DATA_W-1:0]  fwd_data;
    logic               end_frame;
    logic               trunc;

    // Byte to forward while inside a frame, and how the frame closes this cycle.
    always_comb begin
        fwd_data  = iv_data;
        end_frame = 1'b0;
        trunc     = 1'b0;
        if (!i_data_wr) begin
            fwd_data  = {1'b1, 8'h00};  // pad closes a frame that lost its tail
            end_frame = 1'b1;
        end else if (iv_data[8]) begin
            end_frame = 1'b1;
        end else if (byte_cnt == MAX_FRAME_LEN - 11'd1) begin
            fwd_data  = {1'b1, iv_data[7:0]};
            trunc     = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state               <= StIdle;
            byte_cnt            <= '0;
            ov_decap_data       <= '0;
            o_decap_data_wr     <= 1'b0;
            ov_encap_data       <= '0;
            o_encap_data_wr     <= 1'b0;
            ov_encap_descriptor <= '0;
        end else begin
            ov_decap_data   <= '0;
            o_decap_data_wr <= 1'b0;
            ov_encap_data   <= '0;
            o_encap_data_wr <= 1'b0;
            unique case (state)
                StIdle: begin
                    ov_encap_descriptor <= '0;
                    byte_cnt            <= '0;
                    if (i_data_wr) begin
                        if (iv_data[8]) begin
                            byte_cnt <= 11'd1;
                            if (desc_etype(iv_descriptor) == TSMP_ETYPE) begin
                                state           <= StDecap;
                                ov_decap_data   <= iv_data;
                                o_decap_data_wr <= 1'b1;
                            end else begin
                                state               <= StEncap;
                                ov_encap_data       <= iv_data;
                                o_encap_data_wr     <= 1'b1;
                                ov_encap_descriptor <= iv_descriptor;
                            end
                        end else begin
                            state <= StDiscard;
                        end
                    end
                end
                StDecap, StEncap: begin
                    // The encap descriptor register doubles as the per-frame latch.
                    if (state == StDecap) begin
                        ov_decap_data   <= fwd_data;
                        o_decap_data_wr <= 1'b1;
                    end else begin
                        ov_encap_data   <= fwd_data;
                        o_encap_data_wr <= 1'b1;
                    end
                    if (byte_cnt != 11'h7FF) byte_cnt <= byte_cnt + 11'd1;
                    if (trunc) begin
                        state <= StDiscard;
                    end else if (end_frame) begin
                        state <= StIdle;
                    end
                end
                StDiscard: begin
                    ov_encap_descriptor <= '0;
                    byte_cnt            <= '0;
                    if (!i_data_wr || iv_data[8]) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign ov_dispatch_state = state;

`ifdef HCP_DISPATCH_CNT_EN
    logic in_frame;
    logic frame_close;
    logic decap_inc;
    logic encap_inc;
    logic err_inc;

    assign in_frame    = (state == StDecap) || (state == StEncap);
    assign frame_close = in_frame && (end_frame || trunc);
    assign decap_inc   = frame_close && (state == StDecap);
    assign encap_inc   = frame_close && (state == StEncap);
    assign err_inc     = ((state == StIdle) && i_data_wr && !iv_data[8]) ||
                         (in_frame && (!i_data_wr || trunc));

    hcp_dispatch_cnt u_cnt (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .decap_inc (decap_inc),
        .encap_inc (encap_inc),
        .err_inc   (err_inc),
        .decap_cnt (ov_decap_pkt_cnt),
        .encap_cnt (ov_encap_pkt_cnt),
        .err_cnt   (ov_dispatch_err_cnt)
    );
`else
    assign ov_decap_pkt_cnt    = '0;
    assign ov_encap_pkt_cnt    = '0;
    assign ov_dispatch_err_cnt = '0;
`endif

endmodule
